dma_desc_credit_arb: RTL and testbench
======================================

Name: dma_desc_credit_arb

Overview:
- Shares one DMA descriptor channel between PORTS requesters using round-robin arbitration.
- Caps each port's in-flight descriptors with a per-port credit counter.
- Tags each issued descriptor with its source port and routes each returned status back to that port, releasing one credit.
- Sits between requester engines and one read or write descriptor channel of the DMA interface.

Parameters:
- PORTS, 2: number of requester ports (1..16).
- DMA_ADDR_WIDTH, 64: DMA address width.
- LEN_WIDTH, 16: transfer length width.
- S_TAG_WIDTH, 8: requester tag width.
- M_TAG_WIDTH, S_TAG_WIDTH+$clog2(PORTS): output tag width; port index occupies the MSBs.
- MAX_OUTSTANDING, 16: per-port in-flight descriptor limit (>=1).
- CNT_WIDTH, $clog2(MAX_OUTSTANDING+1): width of each credit counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  PORTS  per-port issue enable.
- s_axis_desc_dma_addr  in  PORTS*DMA_ADDR_WIDTH  requester address.
- s_axis_desc_len  in  PORTS*LEN_WIDTH  requester length.
- s_axis_desc_tag  in  PORTS*S_TAG_WIDTH  requester tag.
- s_axis_desc_valid  in  PORTS  requester valid.
- s_axis_desc_ready  out  PORTS  requester ready.
- m_axis_desc_dma_addr  out  DMA_ADDR_WIDTH  issued address.
- m_axis_desc_len  out  LEN_WIDTH  issued length.
- m_axis_desc_tag  out  M_TAG_WIDTH  {port index, requester tag}.
- m_axis_desc_valid  out  1  issued valid.
- m_axis_desc_ready  in  1  DMA ready.
- s_axis_desc_status_tag  in  M_TAG_WIDTH  returned tag.
- s_axis_desc_status_error  in  4  returned error code.
- s_axis_desc_status_valid  in  1  status strobe.
- m_axis_desc_status_tag  out  PORTS*S_TAG_WIDTH  per-port status tag.
- m_axis_desc_status_error  out  PORTS*4  per-port status error.
- m_axis_desc_status_valid  out  PORTS  per-port status strobe.
- outstanding  out  PORTS*CNT_WIDTH  per-port in-flight count.
- busy  out  PORTS  outstanding != 0, per port.

Behaviour:
- Reset (async, rst_n low):
  - All counters cleared, round-robin pointer set to port 0, output register empty.
  - All valids/readies 0; status outputs 0.
- Eligibility: port i is eligible when valid[i] && enable[i] && outstanding[i] < MAX_OUTSTANDING.
- Arbitration:
  - Round-robin; the search starts after the last granted port.
  - The output register loads when it is empty or is being accepted this cycle (m_valid && m_ready).
  - Loading is a grant: s_axis_desc_ready[i] is high combinationally only for the granted port, in that same cycle.
  - At most one grant per cycle.
- Latency: 1 cycle from accepted input to m_axis_desc_valid. Full throughput: one descriptor per cycle while m_axis_desc_ready is held high.
- Output register states:
  - EMPTY -> FULL on grant.
  - FULL -> FULL on accept plus new grant.
  - FULL -> EMPTY on accept with no grant.
  - FULL holds stable (all fields unchanged) while m_ready is low.
- Credits: incremented on grant, not on downstream accept.
- Status routing:
  - On status_valid, port p = tag[M_TAG_WIDTH-1:S_TAG_WIDTH].
  - Register tag low bits and error to port p; pulse m_axis_desc_status_valid[p] for 1 cycle, 1 cycle after input.
  - Decrement outstanding[p].
- Simultaneous grant and status on the same port: counter unchanged.
- Status for p >= PORTS, or for a port with count 0: no output pulse, counter unchanged (dropped).
- Port at MAX_OUTSTANDING: masked from arbitration. A status on that port frees a credit; the port becomes eligible the cycle after the decrement.
- enable[i] low: the port gets no new grants; in-flight statuses still retire.
- A descriptor already in the output register is unaffected by enable.
- PORTS=1: port-index field has zero width; m_tag = s_tag.

Optional Feature:
- Macro: DMA_DESC_CREDIT_ARB_STATS_EN.
- When defined:
  - Adds output stat_error_count, PORTS*16 bits.
  - Each 16-bit counter increments on every routed status with nonzero error and saturates at 16'hFFFF.
  - Counters cleared only by rst_n.
- When undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- PORTS=2, both valid continuously, m_ready=1 -> grants alternate 0,1,0,1. m_tag MSB alternates 0,1. One descriptor per cycle.
- Port 0 only, MAX_OUTSTANDING=4, no statuses -> exactly 4 accepts, then s_ready[0]=0 and outstanding[0]=4.
- Then status tag {1'b0,8'h05} -> m_status_valid[0] pulses with tag 8'h05. outstanding[0]=3. A 5th accept occurs the following cycle.
- m_ready=0 for 10 cycles with valid output -> addr/len/tag held stable, no further s_ready. Release -> accept, next grant in the same cycle.
- Grant and status on port 1 in the same cycle with outstanding[1]=2 -> outstanding[1] stays 2.
- Status with PORTS=3 and port index 3 -> no status pulse, counters unchanged.
- rst_n low mid-burst with outstanding=3 -> async clear: m_valid=0, counters 0, busy=0.
- With the macro defined: 3 statuses with error 4'h1 to port 1 -> stat_error_count[1]=3.

Source files
------------

// File: rtl/dma_desc_credit_arb.sv
// Round-robin DMA descriptor arbiter with per-port credit limits and status return routing.
// Optional per-port error statistics: define DMA_DESC_CREDIT_ARB_STATS_EN.
module dma_desc_credit_arb #(
    parameter int PORTS           = 2,
    parameter int DMA_ADDR_WIDTH  = 64,
    parameter int LEN_WIDTH       = 16,
    parameter int S_TAG_WIDTH     = 8,
    parameter int M_TAG_WIDTH     = S_TAG_WIDTH + $clog2(PORTS),
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PORTS-1:0]              enable,
    input  logic [PORTS*DMA_ADDR_WIDTH-1:0] s_axis_desc_dma_addr,
    input  logic [PORTS*LEN_WIDTH-1:0]    s_axis_desc_len,
    input  logic [PORTS*S_TAG_WIDTH-1:0]  s_axis_desc_tag,
    input  logic [PORTS-1:0]              s_axis_desc_valid,
    output logic [PORTS-1:0]              s_axis_desc_ready,
    output logic [DMA_ADDR_WIDTH-1:0]     m_axis_desc_dma_addr,
    output logic [LEN_WIDTH-1:0]          m_axis_desc_len,
    output logic [M_TAG_WIDTH-1:0]        m_axis_desc_tag,
    output logic                          m_axis_desc_valid,
    input  logic                          m_axis_desc_ready,
    input  logic [M_TAG_WIDTH-1:0]        s_axis_desc_status_tag,
    input  logic [3:0]                    s_axis_desc_status_error,
    input  logic                          s_axis_desc_status_valid,
    output logic [PORTS*S_TAG_WIDTH-1:0]  m_axis_desc_status_tag,
    output logic [PORTS*4-1:0]            m_axis_desc_status_error,
    output logic [PORTS-1:0]              m_axis_desc_status_valid,
    output logic [PORTS*CNT_WIDTH-1:0]    outstanding,
    output logic [PORTS-1:0]              busy
`ifdef DMA_DESC_CREDIT_ARB_STATS_EN
    ,output logic [PORTS*16-1:0]          stat_error_count
`endif
);

    localparam int PW = $clog2(PORTS);
    localparam int IW = (PW > 0) ? PW : 1;

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [IW-1:0]             r_ptr;
    logic [IW-1:0]             w_gidx;
    logic                      w_any;
    logic                      w_load;
    logic                      w_grant;
    logic [PORTS-1:0]          w_elig;
    logic [PORTS-1:0]          w_port_sel;
    logic [PORTS-1:0]          w_cnt_nz;
    logic [PORTS-1:0]          w_dec;
    logic [IW-1:0]             w_st_port;
    logic                      w_st_inrange;
    logic                      w_st_hit;
    logic [M_TAG_WIDTH-1:0]    w_tag;
    logic [DMA_ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]      r_len;
    logic [M_TAG_WIDTH-1:0]    r_tag;
    logic [PORTS-1:0]          r_st_valid;

    // Search begins at r_ptr; descending scan leaves the closest eligible port.
    always_comb begin
        int j;
        w_any  = 1'b0;
        w_gidx = '0;
        j      = 0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            j = int'(r_ptr) + k;
            if (j >= PORTS) j = j - PORTS;
            if (w_elig[j[IW-1:0]]) begin
                w_any  = 1'b1;
                w_gidx = j[IW-1:0];
            end
        end
    end

    assign w_load  = (r_state == S_EMPTY) || m_axis_desc_ready;
    assign w_grant = w_load && w_any;

    generate
        if (PORTS == 1) begin : g_tag1
            assign w_tag     = s_axis_desc_tag;
            assign w_st_port = '0;
        end else begin : g_tagn
            assign w_tag     = {w_gidx, s_axis_desc_tag[w_gidx*S_TAG_WIDTH +: S_TAG_WIDTH]};
            assign w_st_port = s_axis_desc_status_tag[M_TAG_WIDTH-1:S_TAG_WIDTH];
        end
        if (PORTS == (1 << PW)) begin : g_rng_full
            assign w_st_inrange = 1'b1;
        end else begin : g_rng_part
            assign w_st_inrange = (int'(w_st_port) < PORTS);
        end
    endgenerate

    assign w_st_hit = s_axis_desc_status_valid && w_st_inrange && |(w_port_sel & w_cnt_nz);
    assign w_dec    = w_port_sel & {PORTS{w_st_hit}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_EMPTY: w_state_nxt = w_grant ? S_FULL : S_EMPTY;
            S_FULL:  w_state_nxt = (w_grant || !m_axis_desc_ready) ? S_FULL : S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        m_axis_desc_valid = (r_state == S_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_len  <= '0;
            r_tag  <= '0;
            r_ptr  <= '0;
        end else if (w_grant) begin
            r_addr <= s_axis_desc_dma_addr[w_gidx*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH];
            r_len  <= s_axis_desc_len[w_gidx*LEN_WIDTH +: LEN_WIDTH];
            r_tag  <= w_tag;
            r_ptr  <= (int'(w_gidx) == PORTS - 1) ? '0 : w_gidx + IW'(1);
        end
    end

    assign m_axis_desc_dma_addr = r_addr;
    assign m_axis_desc_len      = r_len;
    assign m_axis_desc_tag      = r_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_st_valid <= '0;
        else        r_st_valid <= w_dec;
    end

    assign m_axis_desc_status_valid = r_st_valid;

    genvar i;
    generate
        for (i = 0; i < PORTS; i++) begin : g_port
            logic [CNT_WIDTH-1:0]   r_cnt;
            logic [S_TAG_WIDTH-1:0] r_st_tag;
            logic [3:0]             r_st_err;

            assign w_elig[i] = s_axis_desc_valid[i] && enable[i] &&
                               (r_cnt < CNT_WIDTH'(MAX_OUTSTANDING));
            assign s_axis_desc_ready[i] = w_grant && (w_gidx == IW'(i));
            assign w_port_sel[i] = (w_st_port == IW'(i));
            assign w_cnt_nz[i]   = (r_cnt != '0);

            // Grant and retire in the same cycle cancel out.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (s_axis_desc_ready[i] && !w_dec[i]) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (w_dec[i] && !s_axis_desc_ready[i]) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_st_tag <= '0;
                    r_st_err <= '0;
                end else if (w_dec[i]) begin
                    r_st_tag <= s_axis_desc_status_tag[S_TAG_WIDTH-1:0];
                    r_st_err <= s_axis_desc_status_error;
                end
            end

            assign m_axis_desc_status_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH] = r_st_tag;
            assign m_axis_desc_status_error[i*4 +: 4] = r_st_err;
            assign outstanding[i*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
            assign busy[i] = w_cnt_nz[i];

`ifdef DMA_DESC_CREDIT_ARB_STATS_EN
            logic [15:0] r_err_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_err_cnt <= '0;
                end else if (w_dec[i] && (s_axis_desc_status_error != 4'h0) &&
                             (r_err_cnt != 16'hFFFF)) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end

            assign stat_error_count[i*16 +: 16] = r_err_cnt;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_dma_desc_credit_arb.sv
// Self-checking bench for dma_desc_credit_arb (PORTS=3, MAX_OUTSTANDING=4).
// Descriptor and status scoreboards plus a status-routing vector table.
module tb_dma_desc_credit_arb;

    localparam int P  = 3;
    localparam int AW = 64;
    localparam int LW = 16;
    localparam int SW = 8;
    localparam int MW = 10;
    localparam int MO = 4;
    localparam int CW = 3;

    logic            clk;
    logic            rst_n;
    logic [P-1:0]    enable;
    logic [P*AW-1:0] s_addr;
    logic [P*LW-1:0] s_len;
    logic [P*SW-1:0] s_tag;
    logic [P-1:0]    s_valid;
    logic [P-1:0]    s_ready;
    logic [AW-1:0]   m_addr;
    logic [LW-1:0]   m_len;
    logic [MW-1:0]   m_tag;
    logic            m_valid;
    logic            m_ready;
    logic [MW-1:0]   st_tag;
    logic [3:0]      st_err;
    logic            st_valid;
    logic [P*SW-1:0] ms_tag;
    logic [P*4-1:0]  ms_err;
    logic [P-1:0]    ms_valid;
    logic [P*CW-1:0] outstanding;
    logic [P-1:0]    busy;
`ifdef DMA_DESC_CREDIT_ARB_STATS_EN
    logic [P*16-1:0] stat_cnt;
`endif

    dma_desc_credit_arb #(
        .PORTS(P), .DMA_ADDR_WIDTH(AW), .LEN_WIDTH(LW),
        .S_TAG_WIDTH(SW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .s_axis_desc_dma_addr(s_addr), .s_axis_desc_len(s_len),
        .s_axis_desc_tag(s_tag), .s_axis_desc_valid(s_valid),
        .s_axis_desc_ready(s_ready),
        .m_axis_desc_dma_addr(m_addr), .m_axis_desc_len(m_len),
        .m_axis_desc_tag(m_tag), .m_axis_desc_valid(m_valid),
        .m_axis_desc_ready(m_ready),
        .s_axis_desc_status_tag(st_tag), .s_axis_desc_status_error(st_err),
        .s_axis_desc_status_valid(st_valid),
        .m_axis_desc_status_tag(ms_tag), .m_axis_desc_status_error(ms_err),
        .m_axis_desc_status_valid(ms_valid),
        .outstanding(outstanding), .busy(busy)
`ifdef DMA_DESC_CREDIT_ARB_STATS_EN
        , .stat_error_count(stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [MW-1:0] tag;
    } desc_t;

    typedef struct {
        int         port;
        logic [7:0] tag;
        logic [3:0] err;
    } st_t;

    typedef struct {
        logic [MW-1:0]   tag;
        logic [3:0]      err;
        logic [P-1:0]    exp_vec;
        logic [P*CW-1:0] exp_out;
    } vec_t;

    desc_t dq[$];
    st_t   sq[$];
    vec_t  tbl[6];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail(input string nm);
        n_checks++;
        $display("FAIL %s: got unexpected output, expected none", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic v, input logic [AW-1:0] a,
                            input logic [LW-1:0] l, input logic [SW-1:0] t);
        s_valid[p]         = v;
        s_addr[p*AW +: AW] = a;
        s_len[p*LW +: LW]  = l;
        s_tag[p*SW +: SW]  = t;
    endtask

    task automatic push_desc(input int p);
        desc_t d;
        d.addr = s_addr[p*AW +: AW];
        d.len  = s_len[p*LW +: LW];
        d.tag  = {2'(p), s_tag[p*SW +: SW]};
        dq.push_back(d);
    endtask

    task automatic push_st(input logic [MW-1:0] t, input logic [3:0] e);
        st_t s;
        s.port = int'(t[MW-1:SW]);
        s.tag  = t[SW-1:0];
        s.err  = e;
        sq.push_back(s);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        s_valid  = '0;
        m_ready  = 1'b0;
        st_valid = 1'b0;
        dq.delete();
        sq.delete();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Scoreboard monitor: descriptors on accept, statuses on pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) begin
                if (dq.size() == 0) begin
                    fail("desc_unexpected");
                end else begin
                    desc_t d;
                    d = dq.pop_front();
                    chk("desc_addr", m_addr, d.addr);
                    chk("desc_len", m_len, d.len);
                    chk("desc_tag", m_tag, d.tag);
                end
            end
            for (int i = 0; i < P; i++) begin
                if (ms_valid[i]) begin
                    if (sq.size() == 0) begin
                        fail("status_unexpected");
                    end else begin
                        st_t s;
                        s = sq.pop_front();
                        chk("status_port", i, s.port);
                        chk("status_tag", ms_tag[i*SW +: SW], s.tag);
                        chk("status_err", ms_err[i*4 +: 4], s.err);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{10'h311, 4'h1, 3'b000, {3'd0, 3'd2, 3'd0}};
        tbl[1] = '{10'h022, 4'h0, 3'b000, {3'd0, 3'd2, 3'd0}};
        tbl[2] = '{10'h144, 4'hF, 3'b010, {3'd0, 3'd1, 3'd0}};
        tbl[3] = '{10'h255, 4'h3, 3'b000, {3'd0, 3'd1, 3'd0}};
        tbl[4] = '{10'h166, 4'h0, 3'b010, {3'd0, 3'd0, 3'd0}};
        tbl[5] = '{10'h177, 4'h1, 3'b000, {3'd0, 3'd0, 3'd0}};

        rst_n    = 1'b0;
        enable   = '1;
        s_valid  = '0;
        s_addr   = '0;
        s_len    = '0;
        s_tag    = '0;
        m_ready  = 1'b0;
        st_tag   = '0;
        st_err   = '0;
        st_valid = 1'b0;
        tick();
        tick();
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_s_ready", s_ready, 3'b000);
        chk("rst_outstanding", outstanding, '0);
        chk("rst_busy", busy, 3'b000);
        chk("rst_st_valid", ms_valid, 3'b000);
        chk("rst_st_tag", ms_tag, '0);
        chk("rst_st_err", ms_err, '0);
        rst_n = 1'b1;
        tick();

        // Round-robin alternation between ports 0 and 1
        m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            set_port(0, 1'b1, 64'h0A00_0000 + 64'(c), 16'h0100 + 16'(c), 8'hA0 + 8'(c));
            set_port(1, 1'b1, 64'h0B00_0000 + 64'(c), 16'h0200 + 16'(c), 8'hB0 + 8'(c));
            push_desc(c % 2);
            @(negedge clk);
            chk("rr_grant", s_ready, 3'b001 << (c % 2));
            tick();
        end
        @(negedge clk);
        chk("rr_credit_block", s_ready, 3'b000);
        chk("rr_outstanding", outstanding, {3'd0, 3'd4, 3'd4});
        tick();
        s_valid = '0;
        tick();
        chk("rr_drained", dq.size(), 0);

        // Credit limit on port 0, then release with one status
        do_reset();
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_port(0, 1'b1, 64'h1000 + 64'(c), 16'h40 + 16'(c), 8'h10 + 8'(c));
            push_desc(0);
            @(negedge clk);
            chk("cr_grant", s_ready, 3'b001);
            tick();
        end
        @(negedge clk);
        chk("cr_blocked", s_ready, 3'b000);
        chk("cr_out4", outstanding[0 +: CW], 3'd4);
        tick();
        st_valid = 1'b1;
        st_tag   = 10'h005;
        st_err   = 4'h0;
        push_st(10'h005, 4'h0);
        @(negedge clk);
        chk("cr_still_blocked", s_ready, 3'b000);
        tick();
        st_valid = 1'b0;
        push_desc(0);
        @(negedge clk);
        chk("cr_fifth_grant", s_ready, 3'b001);
        chk("cr_out3", outstanding[0 +: CW], 3'd3);
        tick();
        s_valid = '0;
        @(negedge clk);
        chk("cr_out4_again", outstanding[0 +: CW], 3'd4);
        chk("cr_pulse_1cyc", ms_valid, 3'b000);
        tick();

        // Back-pressure: hold for 10 cycles, then accept and regrant
        do_reset();
        set_port(2, 1'b1, 64'hC0DE_0001, 16'h0100, 8'h5A);
        push_desc(2);
        @(negedge clk);
        chk("bp_first_grant", s_ready, 3'b100);
        tick();
        for (int h = 0; h < 10; h++) begin
            set_port(2, 1'b1, 64'hDEAD_0000 + 64'(h), 16'h0300 + 16'(h), 8'h70 + 8'(h));
            @(negedge clk);
            chk("bp_no_ready", s_ready, 3'b000);
            chk("bp_valid", m_valid, 1'b1);
            chk("bp_addr_hold", m_addr, 64'hC0DE_0001);
            chk("bp_len_hold", m_len, 16'h0100);
            chk("bp_tag_hold", m_tag, 10'h25A);
            tick();
        end
        set_port(2, 1'b1, 64'hBEEF_0002, 16'h0222, 8'h6B);
        m_ready = 1'b1;
        push_desc(2);
        @(negedge clk);
        chk("bp_accept_regrant", s_ready, 3'b100);
        tick();
        s_valid = '0;
        @(negedge clk);
        chk("bp_no_grant", s_ready, 3'b000);
        tick();
        @(negedge clk);
        chk("bp_empty", m_valid, 1'b0);
        tick();

        // Grant and status on port 1 in the same cycle
        do_reset();
        m_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            set_port(1, 1'b1, 64'h2000 + 64'(c), 16'h8 + 16'(c), 8'h20 + 8'(c));
            push_desc(1);
            @(negedge clk);
            chk("gs_grant", s_ready, 3'b010);
            tick();
        end
        s_valid = '0;
        @(negedge clk);
        chk("gs_out2", outstanding[CW +: CW], 3'd2);
        tick();
        set_port(1, 1'b1, 64'h2FFF, 16'h99, 8'h2F);
        push_desc(1);
        st_valid = 1'b1;
        st_tag   = 10'h133;
        st_err   = 4'h2;
        push_st(10'h133, 4'h2);
        @(negedge clk);
        chk("gs_grant_same", s_ready, 3'b010);
        tick();
        s_valid  = '0;
        st_valid = 1'b0;
        @(negedge clk);
        chk("gs_out_unchanged", outstanding[CW +: CW], 3'd2);
        tick();

        // Status routing and drop table (port 3, zero-count ports)
        for (int r = 0; r < 6; r++) begin
            st_valid = 1'b1;
            st_tag   = tbl[r].tag;
            st_err   = tbl[r].err;
            if (tbl[r].exp_vec != '0) push_st(tbl[r].tag, tbl[r].err);
            tick();
            st_valid = 1'b0;
            @(negedge clk);
            chk("tbl_pulse", ms_valid, tbl[r].exp_vec);
            chk("tbl_outstanding", outstanding, tbl[r].exp_out);
            tick();
        end

        // Async reset mid-burst with outstanding=3
        do_reset();
        m_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            set_port(0, 1'b1, 64'h3000 + 64'(c), 16'h30 + 16'(c), 8'h30 + 8'(c));
            push_desc(0);
            tick();
        end
        s_valid = '0;
        m_ready = 1'b0;
        @(negedge clk);
        chk("ar_out3", outstanding[0 +: CW], 3'd3);
        chk("ar_busy", busy, 3'b001);
        chk("ar_valid", m_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_clr_valid", m_valid, 1'b0);
        chk("ar_clr_out", outstanding, '0);
        chk("ar_clr_busy", busy, 3'b000);
        dq.delete();
        sq.delete();
        rst_n = 1'b1;
        tick();

`ifdef DMA_DESC_CREDIT_ARB_STATS_EN
        do_reset();
        m_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            set_port(1, 1'b1, 64'h4000 + 64'(c), 16'h4 + 16'(c), 8'h40 + 8'(c));
            push_desc(1);
            tick();
        end
        s_valid = '0;
        for (int c = 0; c < 3; c++) begin
            st_valid = 1'b1;
            st_tag   = {2'd1, 8'h50 + 8'(c)};
            st_err   = 4'h1;
            push_st({2'd1, 8'h50 + 8'(c)}, 4'h1);
            tick();
        end
        st_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("stat_port1", stat_cnt[16 +: 16], 16'd3);
        chk("stat_port0", stat_cnt[0 +: 16], 16'd0);
        tick();
`endif

        chk("end_desc_q", dq.size(), 0);
        chk("end_status_q", sq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
